floor_arbiter: RTL and testbench

Shares one combinational `floor` unit between two requesters (the two FPU issue ports) using round-robin arbitration. The block wraps the unit in a 2-stage stallable pipeline and supports FLOOR and CEIL operations; CEIL is computed as −floor(−x). It sits between the issue logic and the writeback mux: each result returns with the winning requester's id and tag. Sustained throughput is one result per cycle.

---
 rtl/fpu_pkg.sv | 17 +
 rtl/floor.sv | 55 +++++
 rtl/rr_arb2.sv | 47 ++++
 rtl/floor_arbiter.sv | 153 +++++++++++++++
 tb/tb_floor_arbiter.sv | 331 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/fpu_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Package : fpu_pkg                                                    |
// | Shared FPU types: rounding operation encoding and float width.       |
// | Revision: 1.0 - initial release                                      |
// +----------------------------------------------------------------------+
package fpu_pkg;

  typedef enum logic {
    OP_FLOOR = 1'b0,
    OP_CEIL  = 1'b1
  } round_op_t;

  localparam int FLOAT_W = 32;

endpackage : fpu_pkg
`default_nettype wire

// File: rtl/floor.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : floor                                                      |
// | Combinational binary32 round-toward-minus-infinity.                  |
// | NaN, Inf, +/-0 and integral values pass through unchanged.           |
// | Revision: 1.0 - initial release                                      |
// +----------------------------------------------------------------------+
module floor
  import fpu_pkg::*;
(
  input  logic [FLOAT_W-1:0] src,
  output logic [FLOAT_W-1:0] dst
);

  logic [7:0]         expo;
  logic [4:0]         frac_bits;
  logic [FLOAT_W-1:0] frac_mask;
  logic [FLOAT_W-1:0] trunc;

  // Clear the fractional bits; negative non-integers step one unit away from zero.
  always_comb begin
    expo      = src[30:23];
    frac_bits = '0;
    frac_mask = '0;
    trunc     = '0;
    dst       = src;
    if (expo >= 8'd150) begin
      // Already integral (covers exponent 255: NaN and Inf)
      dst = src;
    end else if (expo < 8'd127) begin
      // |x| < 1: zeros keep their sign, others go to +0 or -1.0
      if (src[30:0] == 31'd0) begin
        dst = src;
      end else if (src[31]) begin
        dst = 32'hBF80_0000;
      end else begin
        dst = 32'h0000_0000;
      end
    end else begin
      frac_bits = 5'(8'd150 - expo);
      frac_mask = (32'd1 << frac_bits) - 32'd1;
      trunc     = src & ~frac_mask;
      if ((src & frac_mask) == 32'd0) begin
        dst = src;
      end else if (src[31]) begin
        // Magnitude increment; a mantissa carry rolls cleanly into the exponent
        dst = trunc + (32'd1 << frac_bits);
      end else begin
        dst = trunc;
      end
    end
  end

endmodule : floor
`default_nettype wire

// File: rtl/rr_arb2.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : rr_arb2                                                    |
// | Two-way round-robin arbiter with a 1-bit priority pointer.           |
// | Revision: 1.0 - initial release                                      |
// +----------------------------------------------------------------------+
module rr_arb2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] valid,
  input  logic       can_accept,
  output logic [1:0] grant
);

  logic prio_q;
  logic prio_d;

  // Grant selection; the pointer moves to the loser only when a grant is issued.
  always_comb begin
    grant  = 2'b00;
    prio_d = prio_q;
    if (can_accept) begin
      case (valid)
        2'b01:   grant = 2'b01;
        2'b10:   grant = 2'b10;
        2'b11:   grant = prio_q ? 2'b10 : 2'b01;
        default: grant = 2'b00;
      endcase
    end
    if (grant[0]) begin
      prio_d = 1'b1;
    end else if (grant[1]) begin
      prio_d = 1'b0;
    end
  end

  // Priority pointer register.
  always_ff @(posedge clk) begin
    if (rst) begin
      prio_q <= 1'b0;
    end else begin
      prio_q <= prio_d;
    end
  end

endmodule : rr_arb2
`default_nettype wire

// File: rtl/floor_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : floor_arbiter                                              |
// | Shares one floor unit between two requesters through a 2-stage      |
// | stallable pipeline. CEIL is computed as -floor(-x).                  |
// | Revision: 1.0 - initial release                                      |
// +----------------------------------------------------------------------+
module floor_arbiter
  import fpu_pkg::*;
#(
  parameter int TAG_W = 5
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               req0_valid,
  output logic               req0_ready,
  input  logic               req0_op,
  input  logic [FLOAT_W-1:0] req0_src,
  input  logic [TAG_W-1:0]   req0_tag,
  input  logic               req1_valid,
  output logic               req1_ready,
  input  logic               req1_op,
  input  logic [FLOAT_W-1:0] req1_src,
  input  logic [TAG_W-1:0]   req1_tag,
  output logic               res_valid,
  input  logic               res_ready,
  output logic               res_id,
  output logic [TAG_W-1:0]   res_tag,
  output logic [FLOAT_W-1:0] res_dest
);

  // Stage 1: operand already sign-adjusted for CEIL
  logic               s1_valid_q, s1_valid_d;
  logic               s1_id_q,    s1_id_d;
  round_op_t          s1_op_q,    s1_op_d;
  logic [TAG_W-1:0]   s1_tag_q,   s1_tag_d;
  logic [FLOAT_W-1:0] s1_src_q,   s1_src_d;

  // Stage 2: final result
  logic               s2_valid_q, s2_valid_d;
  logic               s2_id_q,    s2_id_d;
  logic [TAG_W-1:0]   s2_tag_q,   s2_tag_d;
  logic [FLOAT_W-1:0] s2_dest_q,  s2_dest_d;

  logic               s2_adv;
  logic               s1_can_accept;
  logic [1:0]         grant;
  logic               take;
  logic               sel_id;
  round_op_t          sel_op;
  logic [FLOAT_W-1:0] sel_src;
  logic [TAG_W-1:0]   sel_tag;
  logic [FLOAT_W-1:0] floor_out;

  // Stage advance conditions: S1 may refill in the same cycle it drains.
  always_comb begin
    s2_adv        = s1_valid_q && (!s2_valid_q || res_ready);
    s1_can_accept = !s1_valid_q || s2_adv;
  end

  rr_arb2 u_arb (
    .clk        (clk),
    .rst        (rst),
    .valid      ({req1_valid, req0_valid}),
    .can_accept (s1_can_accept),
    .grant      (grant)
  );

  // Winning requester's payload.
  always_comb begin
    req0_ready = grant[0];
    req1_ready = grant[1];
    take       = grant[0] || grant[1];
    sel_id     = grant[1];
    sel_op     = sel_id ? round_op_t'(req1_op) : round_op_t'(req0_op);
    sel_src    = sel_id ? req1_src : req0_src;
    sel_tag    = sel_id ? req1_tag : req0_tag;
  end

  // S1 next state: load on grant, otherwise empty out when S2 takes the entry.
  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_id_d    = s1_id_q;
    s1_op_d    = s1_op_q;
    s1_tag_d   = s1_tag_q;
    s1_src_d   = s1_src_q;
    if (take) begin
      s1_valid_d = 1'b1;
      s1_id_d    = sel_id;
      s1_op_d    = sel_op;
      s1_tag_d   = sel_tag;
      s1_src_d   = {sel_src[31] ^ (sel_op == OP_CEIL), sel_src[30:0]};
    end else if (s2_adv) begin
      s1_valid_d = 1'b0;
    end
  end

  floor u_floor (
    .src (s1_src_q),
    .dst (floor_out)
  );

  // S2 next state: payload only changes on advance so a stalled result holds.
  always_comb begin
    s2_valid_d = s2_valid_q;
    s2_id_d    = s2_id_q;
    s2_tag_d   = s2_tag_q;
    s2_dest_d  = s2_dest_q;
    if (s2_adv) begin
      s2_valid_d = 1'b1;
      s2_id_d    = s1_id_q;
      s2_tag_d   = s1_tag_q;
      s2_dest_d  = {floor_out[31] ^ (s1_op_q == OP_CEIL), floor_out[30:0]};
    end else if (res_ready) begin
      s2_valid_d = 1'b0;
    end
  end

  // Pipeline registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s1_id_q    <= 1'b0;
      s1_op_q    <= OP_FLOOR;
      s1_tag_q   <= '0;
      s1_src_q   <= '0;
      s2_valid_q <= 1'b0;
      s2_id_q    <= 1'b0;
      s2_tag_q   <= '0;
      s2_dest_q  <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_id_q    <= s1_id_d;
      s1_op_q    <= s1_op_d;
      s1_tag_q   <= s1_tag_d;
      s1_src_q   <= s1_src_d;
      s2_valid_q <= s2_valid_d;
      s2_id_q    <= s2_id_d;
      s2_tag_q   <= s2_tag_d;
      s2_dest_q  <= s2_dest_d;
    end
  end

  // Results come straight from S2 registers.
  always_comb begin
    res_valid = s2_valid_q;
    res_id    = s2_id_q;
    res_tag   = s2_tag_q;
    res_dest  = s2_dest_q;
  end

endmodule : floor_arbiter
`default_nettype wire

// File: tb/tb_floor_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : tb_floor_arbiter                                           |
// | Self-checking bench for floor_arbiter: vector table, scoreboard,     |
// | fairness, backpressure, reset and random floor/ceil sequences.       |
// | Revision: 1.0 - initial release                                      |
// +----------------------------------------------------------------------+
module tb_floor_arbiter;
  import fpu_pkg::*;

  localparam int TAG_W = 5;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             req0_valid = 1'b0, req0_ready, req0_op = 1'b0;
  logic [31:0]      req0_src = '0;
  logic [TAG_W-1:0] req0_tag = '0;
  logic             req1_valid = 1'b0, req1_ready, req1_op = 1'b0;
  logic [31:0]      req1_src = '0;
  logic [TAG_W-1:0] req1_tag = '0;
  logic             res_valid, res_ready = 1'b0, res_id;
  logic [TAG_W-1:0] res_tag;
  logic [31:0]      res_dest;

  floor_arbiter #(.TAG_W(TAG_W)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op),
    .req0_src(req0_src), .req0_tag(req0_tag),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op),
    .req1_src(req1_src), .req1_tag(req1_tag),
    .res_valid(res_valid), .res_ready(res_ready), .res_id(res_id),
    .res_tag(res_tag), .res_dest(res_dest)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic             id;
    logic [TAG_W-1:0] tag;
    logic [31:0]      dest;
  } exp_t;

  typedef struct {
    logic             req;
    logic             op;
    logic [31:0]      src;
    logic [TAG_W-1:0] tag;
    logic [31:0]      dest;
  } vec_t;

  exp_t        sb[$];
  int          grant_log[$];
  int          checks = 0;
  int          errors = 0;
  logic [31:0] exp0 = '0, exp1 = '0;
  vec_t        vecs[16];

  function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h want %h at %0t", name, act, req, $time);
    end
  endfunction

  // Independent real-arithmetic reference for normal and integral operands.
  function automatic logic [31:0] model(input logic op, input logic [31:0] src);
    int  e;
    int  k;
    int  mant;
    real x, r, a;
    logic s;
    e = int'(src[30:23]);
    if (e >= 150) return src;
    x = (8388608.0 + real'(src[22:0])) * (2.0 ** (real'(e) - 150.0));
    if (src[31]) x = -x;
    r = op ? $ceil(x) : $floor(x);
    if (r == 0.0) return {src[31], 31'd0};
    s = (r < 0.0);
    a = s ? -r : r;
    k = 0;
    while (a >= 2.0 ** real'(k + 1)) k++;
    mant = $rtoi((a / (2.0 ** real'(k)) - 1.0) * 8388608.0);
    return {s, 8'(k + 127), mant[22:0]};
  endfunction

  // Scoreboard monitor: sampled on the falling edge, away from the active edge.
  logic             prev_hold = 1'b0;
  logic             prev_id = 1'b0;
  logic [TAG_W-1:0] prev_tag = '0;
  logic [31:0]      prev_dest = '0;
  always @(negedge clk) begin
    if (rst) begin
      sb.delete();
      grant_log.delete();
      prev_hold = 1'b0;
    end else begin
      chk("ready_onehot", {62'd0, req0_ready, req1_ready} == 64'd3, 64'd0);
      if (prev_hold) begin
        chk("hold_valid", res_valid, 1'b1);
        chk("hold_payload", {res_id, res_tag, res_dest}, {prev_id, prev_tag, prev_dest});
      end
      if (res_valid && res_ready) begin
        if (sb.size() == 0) begin
          chk("unexpected_result", 1'b1, 1'b0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("res_id", res_id, e.id);
          chk("res_tag", res_tag, e.tag);
          chk("res_dest", res_dest, e.dest);
        end
      end
      if (req0_valid && req0_ready) begin
        sb.push_back('{1'b0, req0_tag, exp0});
        grant_log.push_back(0);
      end
      if (req1_valid && req1_ready) begin
        sb.push_back('{1'b1, req1_tag, exp1});
        grant_log.push_back(1);
      end
      prev_hold = res_valid && !res_ready;
      prev_id   = res_id;
      prev_tag  = res_tag;
      prev_dest = res_dest;
    end
  end

  task automatic drive(input int r, input logic v, input logic op,
                       input logic [31:0] src, input logic [TAG_W-1:0] tag,
                       input logic [31:0] expv);
    if (r == 0) begin
      req0_valid = v; req0_op = op; req0_src = src; req0_tag = tag; exp0 = expv;
    end else begin
      req1_valid = v; req1_op = op; req1_src = src; req1_tag = tag; exp1 = expv;
    end
  endtask

  // Present one request and hold it until accepted (bounded).
  task automatic send(input int r, input logic op, input logic [31:0] src,
                      input logic [TAG_W-1:0] tag, input logic [31:0] expv);
    @(posedge clk); #1;
    drive(r, 1'b1, op, src, tag, expv);
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if ((r == 0) ? req0_ready : req1_ready) begin
        @(posedge clk); #1;
        if (r == 0) req0_valid = 1'b0; else req1_valid = 1'b0;
        return;
      end
    end
    chk("send_timeout", 1'b1, 1'b0);
    if (r == 0) req0_valid = 1'b0; else req1_valid = 1'b0;
  endtask

  task automatic drain();
    @(posedge clk); #1;
    res_ready = 1'b1;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (sb.size() == 0 && !res_valid) return;
    end
    chk("drain_timeout", 1'b1, 1'b0);
  endtask

  logic rnd_done = 1'b0;

  initial begin
    int a0, a1, total, cyc, acc;
    logic [31:0] bp_src[3];
    logic        bp_op[3];

    vecs[0]  = '{1'b0, 1'b0, 32'h4020_0000, 5'd3,  32'h4000_0000};
    vecs[1]  = '{1'b1, 1'b1, 32'h4020_0000, 5'd4,  32'h4040_0000};
    vecs[2]  = '{1'b0, 1'b0, 32'hBFC0_0000, 5'd5,  32'hC000_0000};
    vecs[3]  = '{1'b1, 1'b1, 32'hBF00_0000, 5'd6,  32'h8000_0000};
    vecs[4]  = '{1'b0, 1'b0, 32'h7FC0_0000, 5'd7,  32'h7FC0_0000};
    vecs[5]  = '{1'b1, 1'b1, 32'h3F00_0000, 5'd8,  32'h3F80_0000};
    vecs[6]  = '{1'b0, 1'b0, 32'h8000_0000, 5'd9,  32'h8000_0000};
    vecs[7]  = '{1'b1, 1'b0, 32'h7F80_0000, 5'd10, 32'h7F80_0000};
    vecs[8]  = '{1'b0, 1'b0, 32'hBE80_0000, 5'd11, 32'hBF80_0000};
    vecs[9]  = '{1'b1, 1'b0, 32'h3FFF_FFFF, 5'd12, 32'h3F80_0000};
    vecs[10] = '{1'b0, 1'b0, 32'hBFFF_FFFF, 5'd13, 32'hC000_0000};
    vecs[11] = '{1'b1, 1'b1, 32'h4B7F_FFFF, 5'd14, 32'h4B7F_FFFF};
    vecs[12] = '{1'b0, 1'b1, 32'h4AFF_FFFF, 5'd15, 32'h4B00_0000};
    vecs[13] = '{1'b1, 1'b0, 32'hC0F0_0000, 5'd16, 32'hC100_0000};
    vecs[14] = '{1'b0, 1'b1, 32'hBFC0_0000, 5'd17, 32'hBF80_0000};
    vecs[15] = '{1'b1, 1'b1, 32'hFF80_0000, 5'd18, 32'hFF80_0000};

    // Reset state
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_res_valid", res_valid, 1'b0);
    chk("rst_ready", {req0_ready, req1_ready}, 2'b00);
    chk("rst_payload", {res_id, res_tag, res_dest}, '0);

    // Directed vectors, one at a time, with latency check
    res_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      send(int'(vecs[i].req), vecs[i].op, vecs[i].src, vecs[i].tag, vecs[i].dest);
      @(negedge clk);
      chk("latency_s1", res_valid, 1'b0);
      @(negedge clk);
      chk("latency_s2", res_valid, 1'b1);
    end
    drain();

    // Backpressure: only two operations fit while the consumer stalls
    bp_src[0] = 32'h4020_0000; bp_op[0] = 1'b0;
    bp_src[1] = 32'hC0F0_0000; bp_op[1] = 1'b0;
    bp_src[2] = 32'h3F00_0000; bp_op[2] = 1'b1;
    @(posedge clk); #1;
    res_ready = 1'b0;
    drive(0, 1'b1, bp_op[0], bp_src[0], 5'd20, 32'h4000_0000);
    acc = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      a0 = int'(req0_ready);
      @(posedge clk); #1;
      if (a0 != 0) begin
        acc++;
        if (acc < 3) drive(0, 1'b1, bp_op[acc], bp_src[acc], 5'(20 + acc), model(bp_op[acc], bp_src[acc]));
      end
    end
    @(negedge clk);
    chk("bp_accepts", acc, 2);
    chk("bp_ready_low", req0_ready, 1'b0);
    chk("bp_first_held", {res_valid, res_dest}, {1'b1, 32'h4000_0000});
    @(posedge clk); #1;
    res_ready = 1'b1;
    for (cyc = 0; cyc < 20; cyc++) begin
      @(negedge clk);
      if (req0_ready) break;
    end
    chk("bp_third_accept", cyc < 20, 1'b1);
    @(posedge clk); #1;
    req0_valid = 1'b0;
    drain();

    // Reset with both stages full and a result pending
    @(posedge clk); #1;
    res_ready = 1'b0;
    send(0, 1'b0, 32'h4020_0000, 5'd1, 32'h4000_0000);
    send(0, 1'b0, 32'h4020_0000, 5'd2, 32'h4000_0000);
    drive(0, 1'b1, 1'b0, 32'h4020_0000, 5'd2, 32'h4000_0000);
    drive(1, 1'b1, 1'b0, 32'h4020_0000, 5'd2, 32'h4000_0000);
    @(negedge clk);
    chk("full_res_valid", res_valid, 1'b1);
    chk("full_ready_low", {req0_ready, req1_ready}, 2'b00);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    res_ready = 1'b1;
    drive(0, 1'b1, 1'b0, 32'h4060_0000, 5'd0, model(1'b0, 32'h4060_0000));
    drive(1, 1'b1, 1'b1, 32'hC060_0000, 5'd16, model(1'b1, 32'hC060_0000));
    @(negedge clk);
    chk("post_rst_res_valid", res_valid, 1'b0);
    chk("post_rst_tie_grant0", {req0_ready, req1_ready}, 2'b10);

    // Fairness: continuing tie, alternate grants at full throughput
    total = 0;
    for (cyc = 1; cyc <= 20; cyc++) begin
      if (cyc > 1) @(negedge clk);
      a0 = int'(req0_ready);
      a1 = int'(req1_ready);
      @(posedge clk); #1;
      total += a0 + a1;
      if (a0 != 0) drive(0, 1'b1, 1'b0, 32'h4060_0000 + 32'(total), 5'(total),
                         model(1'b0, 32'h4060_0000 + 32'(total)));
      if (a1 != 0) drive(1, 1'b1, 1'b1, 32'hC060_0000 + 32'(total), 5'(16 + total),
                         model(1'b1, 32'hC060_0000 + 32'(total)));
      if (total >= 6) begin
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        break;
      end
    end
    chk("fair_cycles", cyc, 6);
    chk("fair_count", grant_log.size(), 6);
    for (int i = 0; i < 6; i++) begin
      if (i < grant_log.size()) chk("fair_order", grant_log[i], i % 2);
    end
    drain();

    // Random floor/ceil from both requesters with a randomly stalling consumer
    fork
      begin
        fork
          begin
            for (int i = 0; i < 24; i++) begin
              logic [31:0] s;
              logic        o;
              s = {1'($urandom_range(0, 1)),
                   8'(($urandom_range(0, 1) != 0) ? $urandom_range(120, 155) : $urandom_range(1, 254)),
                   23'($urandom)};
              o = 1'($urandom_range(0, 1));
              send(0, o, s, 5'($urandom), model(o, s));
            end
          end
          begin
            for (int i = 0; i < 24; i++) begin
              logic [31:0] s;
              logic        o;
              s = {1'($urandom_range(0, 1)),
                   8'(($urandom_range(0, 1) != 0) ? $urandom_range(120, 155) : $urandom_range(1, 254)),
                   23'($urandom)};
              o = 1'($urandom_range(0, 1));
              send(1, o, s, 5'($urandom), model(o, s));
            end
          end
        join
        rnd_done = 1'b1;
      end
      begin
        while (!rnd_done) begin
          @(posedge clk); #1;
          res_ready = ($urandom_range(0, 3) != 0);
        end
      end
    join
    drain();
    chk("sb_empty", sb.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_floor_arbiter
`default_nettype wire
